// File: rtl/gftt_pkg.sv
// Shared widths, FSM encoding and window types for the GFTT gradient stage.
package gftt_pkg;

  localparam int DW = 8;
  localparam int GW = DW + 3;
  localparam int PW = 2 * DW + 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic [DW-1:0] t;
    logic [DW-1:0] m;
    logic [DW-1:0] b;
  } col_t;

  // Sobel 1-2-1 smoothing tap, zero-extended into the signed gradient width.
  function automatic logic signed [GW-1:0] wsum121(input logic [DW-1:0] a,
                                                   input logic [DW-1:0] b,
                                                   input logic [DW-1:0] c);
    logic [GW-1:0] s;
    s = {{(GW-DW){1'b0}}, a} + {{(GW-DW-1){1'b0}}, b, 1'b0} + {{(GW-DW){1'b0}}, c};
    return $signed(s);
  endfunction

endpackage

// File: rtl/gftt_grad_prod.sv
// Stage 2 of the gradient pipe: structure-tensor products with aligned gx/gy,
// valid and line flags.
module gftt_grad_prod
  import gftt_pkg::*;
(
  input  logic                 clk,
  input  logic                 i_clr,
  input  logic                 i_vld,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic signed [GW-1:0] i_gx,
  input  logic signed [GW-1:0] i_gy,
  output logic                 o_vld,
  output logic                 o_first,
  output logic                 o_last,
  output logic signed [GW-1:0] o_gx,
  output logic signed [GW-1:0] o_gy,
  output logic [PW-1:0]        o_ixx,
  output logic [PW-1:0]        o_iyy,
  output logic signed [PW:0]   o_ixy
);

  logic [PW-1:0] w_gx_sq;
  logic [PW-1:0] w_gy_sq;
  logic [PW:0]   w_gx_xy;
  logic [PW:0]   w_gy_xy;
  logic [PW-1:0] w_ixx;
  logic [PW-1:0] w_iyy;
  logic [PW:0]   w_ixy;

  // Low bits of a product of sign-extended operands equal the true signed product,
  // so the result widths are chosen to hold exactly the reachable range.
  assign w_gx_sq = {{(PW-GW){i_gx[GW-1]}}, i_gx};
  assign w_gy_sq = {{(PW-GW){i_gy[GW-1]}}, i_gy};
  assign w_gx_xy = {{(PW+1-GW){i_gx[GW-1]}}, i_gx};
  assign w_gy_xy = {{(PW+1-GW){i_gy[GW-1]}}, i_gy};

  assign w_ixx = w_gx_sq * w_gx_sq;
  assign w_iyy = w_gy_sq * w_gy_sq;
  assign w_ixy = w_gx_xy * w_gy_xy;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      o_vld   <= 1'b0;
      o_first <= 1'b0;
      o_last  <= 1'b0;
      o_gx    <= '0;
      o_gy    <= '0;
      o_ixx   <= '0;
      o_iyy   <= '0;
      o_ixy   <= '0;
    end else begin
      o_vld   <= i_vld;
      o_first <= i_first;
      o_last  <= i_last;
      o_gx    <= i_gx;
      o_gy    <= i_gy;
      o_ixx   <= w_ixx;
      o_iyy   <= w_iyy;
      o_ixy   <= $signed(w_ixy);
    end
  end

endmodule

// File: rtl/gftt_grad.sv
// 3x3 Sobel gradient stage: column window, line FSM with replicated borders,
// registered gx/gy, then the tensor product stage.
module gftt_grad
  import gftt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic                 vin,
  input  logic [DW-1:0]        line0,
  input  logic [DW-1:0]        line1,
  input  logic [DW-1:0]        line2,
  input  logic                 first_smpl,
  input  logic                 last_smpl,
  output logic                 vout,
  output logic signed [GW-1:0] gx,
  output logic signed [GW-1:0] gy,
  output logic [PW-1:0]        ixx,
  output logic [PW-1:0]        iyy,
  output logic signed [PW:0]   ixy,
  output logic                 first_out,
  output logic                 last_out
);

  logic   w_clr;
  state_t r_state;
  state_t w_state_nxt;
  logic   w_load;
  logic   w_shift;
  logic   w_flush;
  logic   w_eval;
  logic   r_first_pend;

  col_t   r_c0;
  col_t   r_c1;
  col_t   w_c_in;
  col_t   w_c2;

  logic signed [GW-1:0] w_gx;
  logic signed [GW-1:0] w_gy;
  logic                 r_v1;
  logic                 r_f1;
  logic                 r_l1;
  logic signed [GW-1:0] r_gx1;
  logic signed [GW-1:0] r_gy1;

  assign w_clr  = rst | ~enb;
  assign w_c_in = {line0, line1, line2};

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge clk) begin
    if (w_clr) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A new line start wins in any state, including the FLUSH cycle.
  // NOTE: each comb output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (vin && first_smpl) begin
      w_state_nxt = last_smpl ? ST_FLUSH : ST_FILL;
    end else begin
      case (r_state)
        ST_IDLE:        w_state_nxt = ST_IDLE;
        ST_FILL,
        ST_RUN:         if (vin) w_state_nxt = last_smpl ? ST_FLUSH : ST_RUN;
        ST_FLUSH:       w_state_nxt = ST_IDLE;
        default:        w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load  = vin & first_smpl;
    w_shift = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      ST_FILL,
      ST_RUN:   w_shift = vin & ~first_smpl;
      ST_FLUSH: w_flush = 1'b1;
      default:  ;
    endcase
    w_eval = w_shift | w_flush;
  end

  // NOTE: window columns are pure data and are always reloaded by a line start
  // before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_c0 <= w_c_in;
      r_c1 <= w_c_in;
    end else if (w_shift) begin
      r_c0 <= r_c1;
      r_c1 <= w_c_in;
    end
  end

  // The right column is the incoming one; on flush the last pixel is replicated.
  assign w_c2 = w_flush ? r_c1 : w_c_in;

  assign w_gx = wsum121(w_c2.t, w_c2.m, w_c2.b) - wsum121(r_c0.t, r_c0.m, r_c0.b);
  assign w_gy = wsum121(r_c0.b, r_c1.b, w_c2.b) - wsum121(r_c0.t, r_c1.t, w_c2.t);

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_first_pend <= 1'b0;
    end else if (w_load) begin
      r_first_pend <= 1'b1;
    end else if (w_eval) begin
      r_first_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_v1  <= 1'b0;
      r_f1  <= 1'b0;
      r_l1  <= 1'b0;
      r_gx1 <= '0;
      r_gy1 <= '0;
    end else begin
      r_v1 <= w_eval;
      r_f1 <= w_eval & r_first_pend;
      r_l1 <= w_flush;
      if (w_eval) begin
        r_gx1 <= w_gx;
        r_gy1 <= w_gy;
      end
    end
  end

  gftt_grad_prod u_prod (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_vld   (r_v1),
    .i_first (r_f1),
    .i_last  (r_l1),
    .i_gx    (r_gx1),
    .i_gy    (r_gy1),
    .o_vld   (vout),
    .o_first (first_out),
    .o_last  (last_out),
    .o_gx    (gx),
    .o_gy    (gy),
    .o_ixx   (ixx),
    .o_iyy   (iyy),
    .o_ixy   (ixy)
  );

endmodule

// File: tb/tb_gftt_grad.sv
// Directed bench for gftt_grad: hand-computed Sobel lines, borders, restart and clears.
module tb_gftt_grad;
  import gftt_pkg::*;

  typedef int       vec_t  [8];
  typedef bit [7:0] pvec_t [8];
  typedef struct {
    int gx;
    int gy;
    int ixx;
    int iyy;
    int ixy;
    int f;
    int l;
    int cyc;
  } out_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enb;
  logic                 vin;
  logic [DW-1:0]        line0;
  logic [DW-1:0]        line1;
  logic [DW-1:0]        line2;
  logic                 first_smpl;
  logic                 last_smpl;
  logic                 vout;
  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;
  logic [PW-1:0]        ixx;
  logic [PW-1:0]        iyy;
  logic signed [PW:0]   ixy;
  logic                 first_out;
  logic                 last_out;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   beat_cyc [8];
  out_t q [$];

  gftt_grad dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .vin        (vin),
    .line0      (line0),
    .line1      (line1),
    .line2      (line2),
    .first_smpl (first_smpl),
    .last_smpl  (last_smpl),
    .vout       (vout),
    .gx         (gx),
    .gy         (gy),
    .ixx        (ixx),
    .iyy        (iyy),
    .ixy        (ixy),
    .first_out  (first_out),
    .last_out   (last_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    out_t o;
    if (vout) begin
      o.gx  = int'(gx);
      o.gy  = int'(gy);
      o.ixx = int'(ixx);
      o.iyy = int'(iyy);
      o.ixy = int'(ixy);
      o.f   = int'(first_out);
      o.l   = int'(last_out);
      o.cyc = cyc;
      q.push_back(o);
    end
  end

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit [7:0] t, input bit [7:0] m, input bit [7:0] b,
                      input bit f, input bit l, input int idx);
    vin        = 1'b1;
    line0      = t;
    line1      = m;
    line2      = b;
    first_smpl = f;
    last_smpl  = l;
    beat_cyc[idx] = cyc;
    @(posedge clk);
    #1;
    vin        = 1'b0;
    first_smpl = 1'b0;
    last_smpl  = 1'b0;
  endtask

  task automatic send_line(input int n, input int gap, input pvec_t t, input pvec_t m,
                           input pvec_t b);
    for (int i = 0; i < n; i++) begin
      beat(t[i], m[i], b[i], i == 0, i == n - 1, i);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic check_line(input string tag, input int n, input vec_t egx, input vec_t egy);
    out_t o;
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) return;
      o = q.pop_front();
      check($sformatf("%s[%0d].gx", tag, i), o.gx, egx[i]);
      check($sformatf("%s[%0d].gy", tag, i), o.gy, egy[i]);
      check($sformatf("%s[%0d].ixx", tag, i), o.ixx, egx[i] * egx[i]);
      check($sformatf("%s[%0d].iyy", tag, i), o.iyy, egy[i] * egy[i]);
      check($sformatf("%s[%0d].ixy", tag, i), o.ixy, egx[i] * egy[i]);
      check($sformatf("%s[%0d].first", tag, i), o.f, (i == 0) ? 1 : 0);
      check($sformatf("%s[%0d].last", tag, i), o.l, (i == n - 1) ? 1 : 0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".vout"},  int'(vout), 0);
    check({tag, ".first"}, int'(first_out), 0);
    check({tag, ".last"},  int'(last_out), 0);
    check({tag, ".gx"},    int'(gx), 0);
    check({tag, ".gy"},    int'(gy), 0);
    check({tag, ".ixx"},   int'(ixx), 0);
    check({tag, ".iyy"},   int'(iyy), 0);
    check({tag, ".ixy"},   int'(ixy), 0);
  endtask

  // Cut a ramp line after three pixels with either rst or enb, finish it without
  // a line start, then expect silence and a clean following line.
  task automatic cut_line(input string tag, input bit use_rst);
    pvec_t ramp;
    ramp = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd0, 8'd0};
    q.delete();
    for (int i = 0; i < 3; i++) beat(ramp[i], ramp[i], ramp[i], i == 0, 1'b0, i);
    if (use_rst) rst = 1'b1;
    else         enb = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    enb = 1'b1;
    @(negedge clk);
    check_zero(tag);
    q.delete();
    for (int i = 3; i < 6; i++) beat(ramp[i], ramp[i], ramp[i], 1'b0, i == 5, i);
    idle(8);
    check({tag, ".stale"}, q.size(), 0);
    send_line(5, 0, ramp, ramp, ramp);
    idle(8);
    check({tag, ".next_count"}, q.size(), 5);
    check_line({tag, ".next"}, 5, '{40, 80, 80, 80, 40, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
  endtask

  initial begin
    pvec_t p_flat, p_ramp, p_zero, p_mid, p_bot, p_edge;
    vec_t  v_zero;
    p_flat = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0};
    p_ramp = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0, 8'd0};
    p_zero = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    p_mid  = '{8'd50, 8'd50, 8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    p_bot  = '{8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    p_edge = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    v_zero = '{0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; enb = 1'b1; vin = 1'b0; first_smpl = 1'b0; last_smpl = 1'b0;
    line0 = '0; line1 = '0; line2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    idle(2);

    // Flat image: zero gradients, flags and pipeline latency.
    q.delete();
    send_line(4, 0, p_flat, p_flat, p_flat);
    idle(8);
    check("flat.count", q.size(), 4);
    if (q.size() == 4) begin
      check("flat.lat_first", q[0].cyc - beat_cyc[1], 2);
      check("flat.lat_last", q[3].cyc - beat_cyc[3], 3);
    end
    check_line("flat", 4, v_zero, v_zero);

    // Horizontal ramp with replicated borders.
    send_line(5, 0, p_ramp, p_ramp, p_ramp);
    idle(8);
    check("ramp.count", q.size(), 5);
    check_line("ramp", 5, '{40, 80, 80, 80, 40, 0, 0, 0}, v_zero);

    // Vertical step between rows.
    send_line(3, 0, p_zero, p_mid, p_bot);
    idle(8);
    check("vstep.count", q.size(), 3);
    check_line("vstep", 3, v_zero, '{400, 400, 400, 0, 0, 0, 0, 0});

    // Full-scale falling edge, continuous and with gaps.
    send_line(4, 0, p_edge, p_edge, p_edge);
    idle(8);
    check("edge.count", q.size(), 4);
    check_line("edge", 4, '{0, -1020, -1020, 0, 0, 0, 0, 0}, v_zero);
    send_line(4, 1, p_edge, p_edge, p_edge);
    idle(8);
    check("edge_gap.count", q.size(), 4);
    check_line("edge_gap", 4, '{0, -1020, -1020, 0, 0, 0, 0, 0}, v_zero);

    // Single-pixel line, then a two-pixel line starting in the FLUSH cycle.
    beat(8'd77, 8'd77, 8'd77, 1'b1, 1'b1, 0);
    beat(8'd30, 8'd20, 8'd10, 1'b1, 1'b0, 1);
    beat(8'd90, 8'd60, 8'd40, 1'b0, 1'b1, 2);
    idle(8);
    check("pair.count", q.size(), 3);
    if (q.size() == 3) begin
      check("single.lat", q[0].cyc - beat_cyc[0], 3);
      check("pair.lat_last", q[2].cyc - beat_cyc[2], 3);
    end
    check_line("single", 1, v_zero, v_zero);
    check_line("pair", 2, '{170, 170, 0, 0, 0, 0, 0, 0}, '{-110, -170, 0, 0, 0, 0, 0, 0});

    cut_line("rst_mid", 1'b1);
    cut_line("enb_mid", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
